// File: rtl/o3_pkg.sv
// Shared types and sizes for the o3 input sweeper: FSM state encoding,
// number of vectors and result/count widths.
package o3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int NUM_VEC  = 16;
    localparam int RESULT_W = 32;
    localparam int CNT_W    = 5;

endpackage

// File: rtl/o3_sweep_ctrl.sv
// Walks {a,b,c,d} through all 16 combinations, holds each for SETTLE cycles and
// captures y/z on the last cycle of each dwell into a packed result word.
module o3_sweep_ctrl
    import o3_pkg::*;
#(
    parameter int SETTLE = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                y_i,
    input  logic                z_i,
    output logic                a_o,
    output logic                b_o,
    output logic                c_o,
    output logic                d_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [RESULT_W-1:0] result_o,
    output logic [CNT_W-1:0]    y_count_o,
    output logic [CNT_W-1:0]    z_count_o,
    output state_e              state_o
);

    // Handshake: start_i is a level request sampled only in IDLE (abort_i wins when
    // both are high); abort_i acts only in SWEEP; done_o pulses for one cycle when
    // all 16 vectors have been captured, and busy_o is high for the whole SWEEP.

    localparam logic [7:0] DCNT_LAST = 8'(SETTLE - 1);
    localparam logic [3:0] VEC_LAST  = 4'(NUM_VEC - 1);

    state_e              state_q, state_d;
    logic [3:0]          vec_q, vec_d;
    logic [7:0]          dcnt_q, dcnt_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]    ycnt_q, ycnt_d;
    logic [CNT_W-1:0]    zcnt_q, zcnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            vec_q    <= '0;
            dcnt_q   <= '0;
            result_q <= '0;
            ycnt_q   <= '0;
            zcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            dcnt_q   <= dcnt_d;
            result_q <= result_d;
            ycnt_q   <= ycnt_d;
            zcnt_q   <= zcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        dcnt_d   = dcnt_q;
        result_d = result_q;
        ycnt_d   = ycnt_q;
        zcnt_d   = zcnt_q;
        case (state_q)
            ST_IDLE: begin
                vec_d  = '0;
                dcnt_d = '0;
                if (start_i && !abort_i) begin
                    state_d  = ST_SWEEP;
                    result_d = '0;
                    ycnt_d   = '0;
                    zcnt_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    vec_d   = '0;
                    dcnt_d  = '0;
                end else if (dcnt_q == DCNT_LAST) begin
                    // Last dwell cycle: y/z reflect the vector driven since the dwell began.
                    result_d[{vec_q, 1'b0} +: 2] = {z_i, y_i};
                    ycnt_d = ycnt_q + {{(CNT_W-1){1'b0}}, y_i};
                    zcnt_d = zcnt_q + {{(CNT_W-1){1'b0}}, z_i};
                    dcnt_d = '0;
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d = vec_q + 4'd1;
                    end
                end else begin
                    dcnt_d = dcnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                vec_d   = '0;
                dcnt_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                vec_d   = '0;
                dcnt_d  = '0;
            end
        endcase
    end

    assign {a_o, b_o, c_o, d_o} = vec_q;
    assign busy_o    = (state_q == ST_SWEEP);
    assign done_o    = (state_q == ST_DONE);
    assign result_o  = result_q;
    assign y_count_o = ycnt_q;
    assign z_count_o = zcnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_o3_sweep_ctrl.sv
// Bench for o3_sweep_ctrl: two instances (SETTLE=10 and SETTLE=1) driven by
// truth-table o3 stubs; expected sweep outcomes are queued and checked on done.
module tb_o3_sweep_ctrl;
  import o3_pkg::*;

  localparam int S0 = 10;
  localparam int S1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // instance 0 (SETTLE=10)
  logic start0 = 1'b0, abort0 = 1'b0, y0, z0, a0, b0, c0, d0, busy0, done0;
  logic [31:0] res0;
  logic [4:0] yc0, zc0;
  state_e st0;
  logic [15:0] ty0 = '0, tz0 = '0;
  logic [3:0] v0;
  assign v0 = {a0, b0, c0, d0};
  assign y0 = ty0[v0];
  assign z0 = tz0[v0];

  // instance 1 (SETTLE=1)
  logic start1 = 1'b0, abort1 = 1'b0, y1, z1, a1, b1, c1, d1, busy1, done1;
  logic [31:0] res1;
  logic [4:0] yc1, zc1;
  state_e st1;
  logic [15:0] ty1 = '0, tz1 = '0;
  logic [3:0] v1;
  assign v1 = {a1, b1, c1, d1};
  assign y1 = ty1[v1];
  assign z1 = tz1[v1];

  o3_sweep_ctrl #(.SETTLE(S0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .abort_i(abort0), .y_i(y0), .z_i(z0),
    .a_o(a0), .b_o(b0), .c_o(c0), .d_o(d0), .busy_o(busy0), .done_o(done0),
    .result_o(res0), .y_count_o(yc0), .z_count_o(zc0), .state_o(st0)
  );

  o3_sweep_ctrl #(.SETTLE(S1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort1), .y_i(y1), .z_i(z1),
    .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1), .busy_o(busy1), .done_o(done1),
    .result_o(res1), .y_count_o(yc1), .z_count_o(zc1), .state_o(st1)
  );

  // Scoreboard entry: {done_edge[31:0], result[31:0], y_count[4:0], z_count[4:0]}
  logic [73:0] exp0_q[$];
  logic [73:0] exp1_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: capture of the first nvec vectors from the y/z truth tables.
  function automatic logic [73:0] model(input logic [15:0] ty, input logic [15:0] tz,
                                        input int nvec, input int done_edge);
    logic [31:0] r = '0;
    int yc = 0;
    int zc = 0;
    for (int v = 0; v < nvec; v++) begin
      r[2*v]   = ty[v];
      r[2*v+1] = tz[v];
      yc += int'(ty[v]);
      zc += int'(tz[v]);
    end
    return {done_edge[31:0], r, yc[4:0], zc[4:0]};
  endfunction

  // Monitors: pop an expectation on every done pulse.
  initial begin : mon0
    int run = 0;
    logic [73:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done0) begin
          if (exp0_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done0_unexpected: got done=1 expected no done at edge %0d", cyc);
          end else begin
            e = exp0_q.pop_front();
            chk("done0_edge", 64'(cyc), 64'(e[73:42]));
            chk("result0", 64'(res0), 64'(e[41:10]));
            chk("y_count0", 64'(yc0), 64'(e[9:5]));
            chk("z_count0", 64'(zc0), 64'(e[4:0]));
            chk("busy0_len", 64'(run), 64'(16*S0));
          end
          run = 0;
        end else if (busy0) run++;
        else run = 0;
      end else run = 0;
    end
  end

  initial begin : mon1
    int run = 0;
    logic [73:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done1) begin
          if (exp1_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done1_unexpected: got done=1 expected no done at edge %0d", cyc);
          end else begin
            e = exp1_q.pop_front();
            chk("done1_edge", 64'(cyc), 64'(e[73:42]));
            chk("result1", 64'(res1), 64'(e[41:10]));
            chk("y_count1", 64'(yc1), 64'(e[9:5]));
            chk("z_count1", 64'(zc1), 64'(e[4:0]));
            chk("busy1_len", 64'(run), 64'(16*S1));
          end
          run = 0;
        end else if (busy1) run++;
        else run = 0;
      end else run = 0;
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle0(input int limit);
    int n = 0;
    while ((exp0_q.size() != 0 || busy0 || done0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      checks++; errors++;
      $display("FAIL timeout0: got %0d pending after %0d cycles expected 0", exp0_q.size(), limit);
      exp0_q.delete();
    end
  endtask

  task automatic wait_idle1(input int limit);
    int n = 0;
    while ((exp1_q.size() != 0 || busy1 || done1) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      checks++; errors++;
      $display("FAIL timeout1: got %0d pending after %0d cycles expected 0", exp1_q.size(), limit);
      exp1_q.delete();
    end
  endtask

  // Launch a sweep on instance 0 from IDLE; returns the start edge.
  task automatic sweep0(input logic [15:0] ty, input logic [15:0] tz, output int e);
    wait_idle0(1000);
    @(negedge clk);
    ty0 = ty; tz0 = tz; start0 = 1'b1;
    e = cyc + 1;
    exp0_q.push_back(model(ty, tz, 16, e + 16*S0));
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic sweep1(input logic [15:0] ty, input logic [15:0] tz, output int e);
    wait_idle1(1000);
    @(negedge clk);
    ty1 = ty; tz1 = tz; start1 = 1'b1;
    e = cyc + 1;
    exp1_q.push_back(model(ty, tz, 16, e + 16*S1));
    @(negedge clk);
    start1 = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int e;
    logic [15:0] ty, tz, xor_t, and_t;
    logic [73:0] m;

    for (int v = 0; v < 16; v++) begin
      xor_t[v] = ^v[3:0];
      and_t[v] = &v[3:0];
    end

    // Reset values while held in reset
    repeat (3) @(negedge clk);
    chk("rst_abcd", 64'(v0), 64'(0));
    chk("rst_busy", 64'(busy0), 64'(0));
    chk("rst_done", 64'(done0), 64'(0));
    chk("rst_result", 64'(res0), 64'(0));
    chk("rst_counts", 64'({yc0, zc0}), 64'(0));
    chk("rst_state", 64'(st0), 64'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full sweep with xor/and stub
    sweep0(xor_t, and_t, e);
    wait_idle0(1000);
    chk("xor_and_result", 64'(res0), 64'h9441_4114);

    // Randomised sweeps, one with start pulses during SWEEP
    for (int i = 0; i < 4; i++) begin
      ty = 16'($urandom_range(0, 16'hFFFF));
      tz = 16'($urandom_range(0, 16'hFFFF));
      sweep0(ty, tz, e);
      if (i == 1) begin
        wait_cyc(e + 47);
        start0 = 1'b1;
        repeat (3) @(negedge clk);
        start0 = 1'b0;
      end
      wait_idle0(1000);
    end

    // Abort sampled at edge 35: vectors 0..2 captured only
    ty = 16'($urandom_range(0, 16'hFFFF));
    tz = 16'($urandom_range(0, 16'hFFFF));
    wait_idle0(1000);
    @(negedge clk);
    ty0 = ty; tz0 = tz; start0 = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    start0 = 1'b0;
    wait_cyc(e + 34);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    m = model(ty, tz, 3, 0);
    chk("abort_state", 64'(st0), 64'(ST_IDLE));
    chk("abort_busy", 64'(busy0), 64'(0));
    chk("abort_abcd", 64'(v0), 64'(0));
    chk("abort_result", 64'(res0), 64'(m[41:10]));
    chk("abort_counts", 64'({yc0, zc0}), 64'(m[9:0]));
    repeat (200) @(negedge clk);
    chk("abort_hold", 64'(res0), 64'(m[41:10]));
    sweep0(ty, tz, e);
    chk("restart_cleared", 64'({res0, yc0, zc0}), 64'(0));
    chk("restart_busy", 64'(busy0), 64'(1));
    wait_idle0(1000);

    // start and abort together in IDLE
    @(negedge clk);
    start0 = 1'b1; abort0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("start_abort_idle", 64'({busy0, st0}), 64'({1'b0, ST_IDLE}));
    end
    start0 = 1'b0; abort0 = 1'b0;

    // start held high: back-to-back sweeps separated by one IDLE cycle
    ty = 16'($urandom_range(0, 16'hFFFF));
    tz = 16'($urandom_range(0, 16'hFFFF));
    @(negedge clk);
    ty0 = ty; tz0 = tz; start0 = 1'b1;
    e = cyc + 1;
    exp0_q.push_back(model(ty, tz, 16, e + 16*S0));
    exp0_q.push_back(model(ty, tz, 16, e + 16*S0 + 2 + 16*S0));
    wait_cyc(e + 16*S0 + 1);
    chk("held_idle_gap", 64'(st0), 64'(ST_IDLE));
    @(negedge clk);
    chk("held_restart", 64'(busy0), 64'(1));
    start0 = 1'b0;
    wait_idle0(1000);

    // Reset asserted mid-sweep at vector 7
    ty = 16'($urandom_range(0, 16'hFFFF));
    tz = 16'($urandom_range(0, 16'hFFFF));
    @(negedge clk);
    ty0 = ty; tz0 = tz; start0 = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    start0 = 1'b0;
    wait_cyc(e + 75);
    chk("pre_reset_vec", 64'(v0), 64'(7));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_abcd", 64'(v0), 64'(0));
    chk("async_rst_busy", 64'(busy0), 64'(0));
    chk("async_rst_result", 64'({res0, yc0, zc0}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", 64'({busy0, done0, st0}), 64'({2'b00, ST_IDLE}));

    // SETTLE=1: vectors step every cycle
    sweep1(16'hFFFF, 16'h0000, e);
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      chk("min_settle_vec", 64'(v1), 64'(k));
    end
    wait_idle1(100);
    chk("min_settle_result", 64'(res1), 64'h5555_5555);
    for (int i = 0; i < 3; i++) begin
      sweep1(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)), e);
      wait_idle1(100);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
